sensor_trace_check: RTL

//  Receive-side checker for tracer-stamped LVDS frames. Sits downstream of the tracer stamper (typically after

---
 rtl/sensor_trace_check.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/sensor_trace_check.sv
// Receive-side checker for tracer-stamped LVDS frames: header lock, per-tracer byte checks, error statistics.
// Latency: sof is combinational from frame_cycle; frame_count updates 1 clk after sof; error stats 2 clks after bad data.
// Backpressure: none; lvds_in is observed every clk and never stalled.
module sensor_trace_check #(
  parameter int DW = 512
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [31:0]   cycles_per_frame,
  input  logic [31:0]   frame_header,
  input  logic [7:0]    tracer_value,
  input  logic [7:0]    tracer_enable,
  input  logic [2:0]    tracer_index,
  output logic [31:0]   rd_tracer_cell,
  input  logic [31:0]   wr_tracer_cell,
  input  logic          wr_tracer_cell_wstrobe,
  input  logic          clear,
  input  logic [DW-1:0] lvds_in,
  output logic          sof,
  output logic [31:0]   frame_count,
  output logic [31:0]   error_count,
  output logic [7:0]    error_mask,
  output logic          first_err_valid,
  output logic [2:0]    first_err_tracer,
  output logic [31:0]   first_err_frame,
  output logic [7:0]    first_err_data
);

  localparam int          NC   = DW / 8;
  localparam int          OW   = $clog2(DW);
  localparam logic [31:0] NCW  = 32'(NC);
  localparam logic [31:0] HDRN = 32'd4;

  // Per-tracer cell index registers (cell = cycle * NC + byte lane).
  logic [31:0] tracer_cell [8];

  // Frame position: 0..3 are header hunt states, 4.. is the frame body.
  logic [31:0] frame_cycle;
  logic [31:0] frame_cycle_nxt;
  logic [7:0]  hdr_byte;
  logic        hdr_match;

  // Stage-1 compare results for the current lvds_in cycle.
  logic [7:0]  mis_d;
  logic [7:0]  rx_d [8];

  // Stage-1 registers: mismatch flags, received bytes and frame_count snapshot.
  logic [7:0]  mis_q;
  logic [7:0]  rx_q [8];
  logic [31:0] frm_q;

  // Stage-2 helpers.
  logic [3:0]  mis_pop;
  logic [2:0]  mis_first;
  logic [32:0] err_sum;
  logic [31:0] err_next;

  // Tracer cell register file; writes are ignored while in reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < 8; i++) tracer_cell[i] <= '0;
    end else if (wr_tracer_cell_wstrobe) begin
      tracer_cell[tracer_index] <= wr_tracer_cell;
    end
  end

  assign rd_tracer_cell = tracer_cell[tracer_index];

  // Header byte expected at the current hunt position; byte 0 is the LSB of frame_header.
  always_comb begin
    hdr_byte = frame_header[7:0];
    case (frame_cycle[1:0])
      2'd0:    hdr_byte = frame_header[7:0];
      2'd1:    hdr_byte = frame_header[15:8];
      2'd2:    hdr_byte = frame_header[23:16];
      default: hdr_byte = frame_header[31:24];
    endcase
  end

  assign hdr_match = (lvds_in == {NC{hdr_byte}});

  // Frame position state register; reset drops lock so a full fresh header is needed.
  always_ff @(posedge clk) begin
    if (!resetn) frame_cycle <= '0;
    else         frame_cycle <= frame_cycle_nxt;
  end

  // Next frame position: a header miss goes back to 0 without retesting the same cycle as byte 0.
  always_comb begin
    frame_cycle_nxt = '0;
    if (frame_cycle < HDRN) begin
      frame_cycle_nxt = hdr_match ? frame_cycle + 32'd1 : 32'd0;
    end else if (frame_cycle >= cycles_per_frame - 32'd1) begin
      frame_cycle_nxt = '0;
    end else begin
      frame_cycle_nxt = frame_cycle + 32'd1;
    end
  end

  assign sof = (frame_cycle == HDRN);

  // Per-tracer cell decode and byte compare; header-cycle cells are never checked.
  for (genvar g = 0; g < 8; g++) begin : g_trc
    logic [31:0]   cell_cyc;
    logic [OW-1:0] cell_bit;
    logic [7:0]    rx;

    assign cell_cyc = tracer_cell[g] / NCW;
    assign cell_bit = OW'((tracer_cell[g] % NCW) * 32'd8);
    assign rx       = lvds_in[cell_bit +: 8];
    assign rx_d[g]  = rx;
    assign mis_d[g] = tracer_enable[g] && (cell_cyc >= HDRN)
                      && (frame_cycle == cell_cyc) && (rx != tracer_value);
  end

  // Stage 1: register mismatch flags with the bytes seen and the frame_count of that cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mis_q <= '0;
      frm_q <= '0;
      for (int i = 0; i < 8; i++) rx_q[i] <= '0;
    end else begin
      mis_q <= mis_d;
      frm_q <= frame_count;
      for (int i = 0; i < 8; i++) rx_q[i] <= rx_d[i];
    end
  end

  // Mismatch population count and lowest-index mismatching tracer.
  always_comb begin
    mis_pop   = '0;
    mis_first = '0;
    for (int i = 0; i < 8; i++) mis_pop = mis_pop + 4'(mis_q[i]);
    for (int i = 7; i >= 0; i--) begin
      if (mis_q[i]) mis_first = 3'(i);
    end
  end

  // Saturating error accumulation.
  always_comb begin
    err_sum  = {1'b0, error_count} + 33'(mis_pop);
    err_next = err_sum[32] ? 32'hFFFF_FFFF : err_sum[31:0];
  end

  // Stage 2: statistics; clear wins over any same-cycle increment or capture.
  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      frame_count      <= '0;
      error_count      <= '0;
      error_mask       <= '0;
      first_err_valid  <= 1'b0;
      first_err_tracer <= '0;
      first_err_frame  <= '0;
      first_err_data   <= '0;
    end else begin
      if (sof && (frame_count != 32'hFFFF_FFFF)) frame_count <= frame_count + 32'd1;
      if (mis_q != 8'd0) begin
        error_count <= err_next;
        error_mask  <= error_mask | mis_q;
        if (!first_err_valid) begin
          first_err_valid  <= 1'b1;
          first_err_tracer <= mis_first;
          first_err_frame  <= frm_q;
          first_err_data   <= rx_q[mis_first];
        end
      end
    end
  end

endmodule
